// File: rtl/cache_line_fill.sv
// cache_line_fill: refill engine for the 8-way, 8-set, 256-bit-block data cache.
// Requests one block from memory and collects BEATS narrow beats into a buffer.
// Then issues a single full-block write at the latched way and index, or a
// one-cycle error pulse if any beat carried a bus error or a beat timed out.
module cache_line_fill #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned BEAT_W  = 32,
    parameter int unsigned BEATS   = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      fill_req,
    input  logic [ADDR_W-1:0]         fill_addr,
    input  logic [2:0]                fill_way,
    input  logic [2:0]                fill_index,
    output logic                      fill_busy,
    output logic                      fill_done,
    output logic                      fill_err,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [ADDR_W-1:0]         mem_req_addr,
    input  logic                      mem_rdata_valid,
    input  logic [BEAT_W-1:0]         mem_rdata,
    input  logic                      mem_rdata_err,
    output logic [2:0]                cache_way,
    output logic [2:0]                cache_index,
    output logic                      cache_write,
    output logic                      cache_data_sel,
    output logic [BEAT_W*BEATS-1:0]   cache_block
);

    localparam int unsigned BLK_W = BEAT_W * BEATS;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BEATS - 1);
    localparam logic [TO_W-1:0]   TO_LIMIT   = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0]   TO_PRELIM  = TO_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(5'h1f);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RECV,
        WRITE,
        ERR
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0]  beat_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              err_flag;
    logic [BLK_W-1:0]  blk_buf;
    logic [BLK_W-1:0]  blk_next;
    logic [2:0]        way_q;
    logic [2:0]        index_q;
    logic [ADDR_W-1:0] addr_q;

    logic beat_in;
    logic last_beat;
    logic timed_out;

    // Beat acceptance qualifiers and the buffer image with the current beat merged in
    always_comb begin
        beat_in   = (state == RECV) && mem_rdata_valid;
        last_beat = beat_in && (beat_cnt == LAST_BEAT);
        timed_out = (state == RECV) && !mem_rdata_valid && (to_cnt == TO_PRELIM);
        blk_next  = blk_buf;
        if (beat_in) begin
            blk_next[beat_cnt*BEAT_W +: BEAT_W] = mem_rdata;
        end
    end

    // Next-state selection
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (fill_req) state_next = REQ;
            REQ:   if (mem_req_ready) state_next = RECV;
            RECV: begin
                // the final beat's own error bit counts alongside earlier ones
                if (last_beat) begin
                    state_next = (err_flag || mem_rdata_err) ? ERR : WRITE;
                end else if (timed_out) begin
                    state_next = ERR;
                end
            end
            WRITE: state_next = IDLE;
            ERR:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request latch, beat/timeout counters, error flag and block buffer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_cnt <= '0;
            to_cnt   <= '0;
            err_flag <= 1'b0;
            blk_buf  <= '0;
            way_q    <= '0;
            index_q  <= '0;
            addr_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fill_req) begin
                        way_q    <= fill_way;
                        index_q  <= fill_index;
                        addr_q   <= fill_addr & ALIGN_MASK;
                        beat_cnt <= '0;
                        to_cnt   <= '0;
                        err_flag <= 1'b0;
                    end
                end
                RECV: begin
                    if (beat_in) begin
                        blk_buf <= blk_next;
                        to_cnt  <= '0;
                        if (!last_beat) begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                        if (mem_rdata_err) begin
                            err_flag <= 1'b1;
                        end
                    end else if (to_cnt != TO_LIMIT) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Cache-side outputs load only on entry to WRITE and hold between writes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cache_way   <= '0;
            cache_index <= '0;
            cache_block <= '0;
        end else if (state == RECV && state_next == WRITE) begin
            cache_way   <= way_q;
            cache_index <= index_q;
            cache_block <= blk_next;
        end
    end

    assign fill_busy      = (state != IDLE);
    assign fill_done      = (state == WRITE);
    assign fill_err       = (state == ERR);
    assign cache_write    = (state == WRITE);
    assign mem_req_valid  = (state == REQ);
    assign mem_req_addr   = addr_q;
    assign cache_data_sel = 1'b0;

endmodule

// File: tb/tb_cache_line_fill.sv
// tb_cache_line_fill: randomized self-checking bench for cache_line_fill.
// The reference model tracks each fill as a list of beats plus an outcome
// (write or abort) and the cache-side values that must be held between writes.
module tb_cache_line_fill;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned BEAT_W  = 32;
    localparam int unsigned BEATS   = 8;
    localparam int unsigned TIMEOUT = 255;
    localparam int unsigned BLK_W   = BEAT_W * BEATS;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              fill_req;
    logic [ADDR_W-1:0] fill_addr;
    logic [2:0]        fill_way;
    logic [2:0]        fill_index;
    logic              fill_busy;
    logic              fill_done;
    logic              fill_err;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_rdata_valid;
    logic [BEAT_W-1:0] mem_rdata;
    logic              mem_rdata_err;
    logic [2:0]        cache_way;
    logic [2:0]        cache_index;
    logic              cache_write;
    logic              cache_data_sel;
    logic [BLK_W-1:0]  cache_block;

    cache_line_fill #(
        .ADDR_W (ADDR_W),
        .BEAT_W (BEAT_W),
        .BEATS  (BEATS),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .fill_req       (fill_req),
        .fill_addr      (fill_addr),
        .fill_way       (fill_way),
        .fill_index     (fill_index),
        .fill_busy      (fill_busy),
        .fill_done      (fill_done),
        .fill_err       (fill_err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rdata_valid(mem_rdata_valid),
        .mem_rdata      (mem_rdata),
        .mem_rdata_err  (mem_rdata_err),
        .cache_way      (cache_way),
        .cache_index    (cache_index),
        .cache_write    (cache_write),
        .cache_data_sel (cache_data_sel),
        .cache_block    (cache_block)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // Model state: what the cache side must show (last successful write)
    logic [2:0]       m_way   = '0;
    logic [2:0]       m_idx   = '0;
    logic [BLK_W-1:0] m_block = '0;

    // Beats the memory model returns for the next fill
    logic [BEAT_W-1:0] beat_q [BEATS];

    task automatic check(input string tag, input logic [BLK_W-1:0] got, input logic [BLK_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_beats;
        for (int i = 0; i < BEATS; i++) beat_q[i] = $urandom;
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_busy"},  fill_busy, 0);
        check({tag, "_done"},  fill_done, 0);
        check({tag, "_err"},   fill_err, 0);
        check({tag, "_valid"}, mem_req_valid, 0);
        check({tag, "_addr"},  mem_req_addr, 0);
        check({tag, "_way"},   cache_way, 0);
        check({tag, "_idx"},   cache_index, 0);
        check({tag, "_wr"},    cache_write, 0);
        check({tag, "_sel"},   cache_data_sel, 0);
        check({tag, "_blk"},   cache_block, 0);
    endtask

    task automatic chk_hold(input string tag);
        check({tag, "_way"}, cache_way, m_way);
        check({tag, "_idx"}, cache_index, m_idx);
        check({tag, "_blk"}, cache_block, m_block);
    endtask

    // Idle cycles with junk on the memory side; nothing may change
    task automatic idle_check(input int n);
        for (int c = 0; c < n; c++) begin
            fill_req        = 1'b0;
            mem_rdata_valid = 1'($urandom);
            mem_rdata       = $urandom;
            mem_rdata_err   = 1'($urandom);
            mem_req_ready   = 1'($urandom);
            @(negedge clk);
            check("idle_busy", fill_busy, 0);
            check("idle_wr", cache_write, 0);
            check("idle_valid", mem_req_valid, 0);
            chk_hold("idle");
            next_cycle();
        end
        mem_rdata_valid = 1'b0;
        mem_rdata_err   = 1'b0;
        mem_req_ready   = 1'b0;
    endtask

    // One complete refill; starts in an IDLE cycle, ends at the start of the next IDLE cycle.
    // gap < 0 picks a random 0..3 cycle gap before each beat.
    task automatic do_fill(input logic [ADDR_W-1:0] addr, input logic [2:0] way, input logic [2:0] idx,
                           input int rdy_wait, input int gap, input int err_beat, input int nbeats,
                           input bit hold);
        logic [BLK_W-1:0]  blk;
        logic [ADDR_W-1:0] exp_addr;
        bit                exp_err;
        int                g;
        exp_addr = {addr[ADDR_W-1:5], 5'b0};
        exp_err  = (nbeats < BEATS) || (err_beat >= 0 && err_beat < nbeats);
        for (int i = 0; i < BEATS; i++) blk[i*BEAT_W +: BEAT_W] = beat_q[i];

        fill_req        = 1'b1;
        fill_addr       = addr;
        fill_way        = way;
        fill_index      = idx;
        mem_req_ready   = 1'b0;
        mem_rdata_valid = 1'b0;
        mem_rdata_err   = 1'b0;
        @(negedge clk);
        check("accept_busy", fill_busy, 0);
        next_cycle();

        for (int w = 0; w <= rdy_wait; w++) begin
            if (!hold) fill_req = 1'b0;
            fill_addr       = $urandom;
            fill_way        = 3'($urandom);
            fill_index      = 3'($urandom);
            mem_req_ready   = (w == rdy_wait);
            mem_rdata_valid = 1'b1;
            mem_rdata       = $urandom;
            mem_rdata_err   = 1'($urandom);
            @(negedge clk);
            check("req_valid", mem_req_valid, 1);
            check("req_addr", mem_req_addr, exp_addr);
            check("req_busy", fill_busy, 1);
            next_cycle();
        end
        mem_req_ready = 1'b0;

        for (int b = 0; b < nbeats; b++) begin
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            for (int k = 0; k < g; k++) begin
                mem_rdata_valid = 1'b0;
                mem_rdata       = $urandom;
                mem_rdata_err   = 1'($urandom);
                fill_addr       = $urandom;
                @(negedge clk);
                check("gap_valid", mem_req_valid, 0);
                check("gap_wr", cache_write, 0);
                next_cycle();
            end
            mem_rdata_valid = 1'b1;
            mem_rdata       = beat_q[b];
            mem_rdata_err   = (b == err_beat);
            @(negedge clk);
            check("beat_wr", cache_write, 0);
            check("beat_busy", fill_busy, 1);
            next_cycle();
        end
        mem_rdata_valid = 1'b0;
        mem_rdata_err   = 1'b0;

        if (nbeats < BEATS) begin
            for (int t = 0; t < TIMEOUT; t++) begin
                @(negedge clk);
                check("to_early", fill_err, 0);
                next_cycle();
            end
            // stray beat arriving with the abort is ignored
            mem_rdata_valid = 1'b1;
            mem_rdata       = $urandom;
        end

        @(negedge clk);
        check("end_sel", cache_data_sel, 0);
        if (exp_err) begin
            check("abort_err", fill_err, 1);
            check("abort_wr", cache_write, 0);
            check("abort_done", fill_done, 0);
            chk_hold("abort");
        end else begin
            m_way   = way;
            m_idx   = idx;
            m_block = blk;
            check("wr_strobe", cache_write, 1);
            check("wr_done", fill_done, 1);
            check("wr_err", fill_err, 0);
            chk_hold("wr");
        end
        next_cycle();
        mem_rdata_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        fill_req        = 1'b0;
        fill_addr       = '0;
        fill_way        = '0;
        fill_index      = '0;
        mem_req_ready   = 1'b0;
        mem_rdata_valid = 1'b0;
        mem_rdata       = '0;
        mem_rdata_err   = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("rst");
        next_cycle();
        reset = 1'b1;

        // Directed: aligned address, back-to-back beats, write lands in cycle 10
        for (int i = 0; i < BEATS; i++) beat_q[i] = 32'h1111_1111 * (i + 1);
        do_fill(32'h0000_1234, 3'd5, 3'd3, 0, 0, -1, BEATS, 1'b0);
        check("dir_lo", cache_block[31:0], 32'h1111_1111);
        check("dir_hi", cache_block[255:224], 32'h8888_8888);
        idle_check(2);

        // Ready held off 4 cycles, 2-cycle gaps between beats
        rand_beats();
        do_fill(32'hdead_beef, 3'd2, 3'd7, 4, 2, -1, BEATS, 1'b0);
        idle_check(1);

        // Bus error on beat 3: all beats consumed, abort instead of write
        rand_beats();
        do_fill(32'h0001_0040, 3'd6, 3'd1, 1, 0, 3, BEATS, 1'b0);
        idle_check(1);

        // Only 5 beats: timeout abort, then a normal fill
        rand_beats();
        do_fill(32'h0badc0de, 3'd1, 3'd4, 0, 1, -1, 5, 1'b0);
        idle_check(3);
        rand_beats();
        do_fill(32'h7000_0010, 3'd0, 3'd2, 0, 0, -1, BEATS, 1'b0);

        // Reset after beat 4: everything drops to zero at once
        rand_beats();
        fill_req  = 1'b1;
        fill_addr = 32'h1234_5678;
        fill_way  = 3'd7;
        fill_index = 3'd6;
        next_cycle();
        fill_req      = 1'b0;
        mem_req_ready = 1'b1;
        next_cycle();
        mem_req_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            mem_rdata_valid = 1'b1;
            mem_rdata       = beat_q[b];
            next_cycle();
        end
        mem_rdata_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        m_way   = '0;
        m_idx   = '0;
        m_block = '0;
        chk_zero("midrst");
        @(negedge clk);
        chk_zero("midrst_hold");
        next_cycle();
        reset = 1'b1;
        idle_check(1);
        rand_beats();
        do_fill(32'h4444_4444, 3'd3, 3'd5, 0, 0, -1, BEATS, 1'b0);

        // fill_req held high: back-to-back fills with one IDLE cycle between
        for (int f = 0; f < 3; f++) begin
            rand_beats();
            do_fill($urandom, 3'($urandom), 3'($urandom), 0, 0, -1, BEATS, 1'b1);
        end
        fill_req = 1'b0;
        idle_check(2);

        // Randomized fills: ready delays, gaps, error beats, occasional timeouts
        for (int n = 0; n < 40; n++) begin
            int rw;
            int eb;
            int nb;
            rand_beats();
            rw = int'($urandom_range(0, 4));
            eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, BEATS - 1)) : -1;
            nb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, BEATS - 1)) : BEATS;
            do_fill($urandom, 3'($urandom), 3'($urandom), rw, -1, eb, nb, 1'b0);
            idle_check(int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/cache_line_fill.md
Name: cache_line_fill

Overview:
- Refill engine that feeds the 8-way, 8-set, 256-bit-block data cache array.
- On a miss it requests one block from memory and collects BEATS narrow beats into a block buffer.
- It then performs one full-block write into the cache at the latched way and index.
- The cache array is the consumer of block writes; this unit is the producer that assembles them from the memory side.

Parameters:
ADDR_W, 32, byte-address width
BEAT_W, 32, memory read-data beat width
BEATS, 8, beats per block (BEAT_W*BEATS = 256 = cache block width)
TIMEOUT, 255, max idle cycles waiting for any single beat before abort

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
fill_req  in  1  start a refill; sampled only in IDLE
fill_addr  in  ADDR_W  miss byte address
fill_way  in  3  victim way
fill_index  in  3  target set
fill_busy  out  1  high in every state except IDLE
fill_done  out  1  one-cycle pulse: block written to cache
fill_err  out  1  one-cycle pulse: refill aborted, no cache write
mem_req_valid  out  1  memory read request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_W  block-aligned address, low 5 bits zero
mem_rdata_valid  in  1  beat valid
mem_rdata  in  BEAT_W  beat data
mem_rdata_err  in  1  beat carries bus error; qualified by mem_rdata_valid
cache_way  out  3  way to cache
cache_index  out  3  index to cache
cache_write  out  1  cache write strobe
cache_data_sel  out  1  held 0 = full-block write mask
cache_block  out  256  block to cache

Behaviour:
- Reset (reset=0, async):
  - state IDLE; beat counter 0; timeout counter 0; error flag 0.
  - Block buffer all zeros; latched way, index and addr 0.
  - All outputs 0.
- Registers and outputs:
  - All outputs are registered or decoded from state; no combinational input-to-output path.
  - cache_data_sel is constant 0.
- IDLE:
  - fill_req=1 latches fill_way, fill_index and {fill_addr[ADDR_W-1:5],5'b0}.
  - Clears beat counter, timeout counter and error flag, then goes to REQ.
  - fill_req outside IDLE is ignored; it is not queued.
- REQ:
  - mem_req_valid=1; mem_req_addr = latched address.
  - Stays in REQ until mem_req_valid & mem_req_ready, then goes to RECV.
  - Valid is never dropped before ready.
  - mem_rdata_valid in REQ is ignored.
- RECV:
  - Each mem_rdata_valid cycle stores beat k (k = counter) into buffer bits [BEAT_W*k+BEAT_W-1 : BEAT_W*k].
  - Counter increments; timeout counter clears.
  - A beat with mem_rdata_err=1 sets the error flag; its data is still counted.
  - When beat BEATS-1 is accepted: error flag set (including set this cycle) -> ERR; otherwise -> WRITE.
  - A cycle without a beat increments the timeout counter.
  - Timeout counter reaching TIMEOUT -> ERR; any later beats are ignored.
- WRITE (exactly one cycle):
  - cache_write=1, fill_done=1.
  - cache_way, cache_index and cache_block show the latched values and stay stable the whole cycle.
  - Next state is IDLE.
- ERR (exactly one cycle): fill_err=1, cache_write=0, then IDLE.
- Between writes:
  - cache_way, cache_index and cache_block hold their last values.
  - cache_write is 0 in every state except WRITE.
- Latency, with ready and beats back-to-back:
  - req accepted at edge 0; REQ in cycle 1 with handshake.
  - Beats in cycles 2..9; WRITE and done in cycle 10.
  - Minimum fill is BEATS+3 cycles.
- Counter widths:
  - Beat counter is clog2(BEATS) bits and does not wrap inside one fill; it is cleared at accept.
  - Timeout counter saturates at TIMEOUT.
- Reset mid-operation: immediate return to IDLE, all outputs 0, no partial cache write.
- fill_req in the WRITE or ERR cycle is ignored; the earliest new accept is the following IDLE cycle.

Test Plan:
- Reset then fill_req with addr=0x0000_1234, way=5, index=3; ready=1; beats 0x11111111..0x88888888 back-to-back -> mem_req_addr=0x0000_1220; cache_write and fill_done high one cycle at cycle 10; cache_way=5, cache_index=3; cache_block[31:0]=0x11111111, cache_block[255:224]=0x88888888.
- mem_req_ready held low 4 cycles, beats with 2-cycle gaps -> mem_req_valid high 5 cycles with stable address; block assembled correctly; single cache_write pulse.
- Beat 3 has mem_rdata_err=1 -> all 8 beats consumed; fill_err pulses once; cache_write never asserted; fill_busy low the cycle after.
- Only 5 beats sent, TIMEOUT=255 -> fill_err pulses 255 cycles after beat 5; later stray beats ignored; next fill works normally.
- Reset asserted after beat 4 -> outputs 0 immediately; no cache_write; new fill completes with only its own data.
- fill_req held high continuously -> back-to-back fills; each new accept occurs only in IDLE after WRITE; busy drops for exactly one cycle between fills.
